uart_tx_arb_ctrl: RTL and testbench

UART_TX_ARB_CTRL -- requirements
Module: uart_tx_arb_ctrl

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/uart_tx_arb_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_tx_arb_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller: FSM encoding, frame
// lengths and the parity function.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StGap   = 2'd3
  } tx_state_e;

  // Shift cycles per frame: 8 data bits + parity + stop, or 8 data bits + stop.
  localparam logic [3:0] FRAME_SHIFTS_PAR   = 4'd10;
  localparam logic [3:0] FRAME_SHIFTS_NOPAR = 4'd9;

  // Slot-8 bit: parity when enabled, otherwise a stop bit (1).
  function automatic logic parity_calc(input logic [7:0] data, input logic en, input logic odd);
    return en ? ((^data) ^ odd) : 1'b1;
  endfunction

  function automatic logic [3:0] frame_shifts(input logic en);
    return en ? FRAME_SHIFTS_PAR : FRAME_SHIFTS_NOPAR;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational; the last-grant
// register only moves when the controller actually accepts a request.
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic accept_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  logic last_q, last_d;

  // Lone requester wins; with both pending the one not granted last wins.
  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      gnt_id_o = ~last_q;
    end else begin
      gnt_id_o = req1_i;
    end
    last_d = accept_i ? gnt_id_o : last_q;
  end

  // Last-grant register; resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/uart_tx_arb_ctrl.sv
// UART transmit controller: arbitrates two byte requesters and sequences the
// load/shift strobes of a downstream PISO, one bit-time per clock.
module uart_tx_arb_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       tx_clk,
  input  logic       tx_rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       cfg_parity_en,
  input  logic       cfg_parity_odd,
  output logic       load,
  output logic       shift,
  output logic [7:0] p_data_out,
  output logic       parity_bit,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done
);

  localparam int unsigned GapW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GapLastInt = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GapW-1:0] GapLast = GapLastInt[GapW-1:0];

  tx_state_e       state_q;
  logic            load_q, shift_q, frame_done_q, busy_q;
  logic [7:0]      data_q;
  logic            par_en_q, par_odd_q, grant_q;
  logic [3:0]      shift_cnt_q;
  logic [GapW-1:0] gap_cnt_q;

  logic            gnt_valid, gnt_id, accept;
  logic [3:0]      last_shift;

  rr_arb2 u_arb (
    .clk_i      (tx_clk),
    .rst_i      (tx_rst),
    .req0_i     (req0_valid),
    .req1_i     (req1_valid),
    .accept_i   (accept),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

  // Acceptance is only possible in IDLE and never while reset is held.
  assign accept     = (state_q == StIdle) && gnt_valid && !tx_rst;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;

  // Frame length follows the parity setting latched at acceptance.
  assign last_shift = frame_shifts(par_en_q) - 4'd1;

  // Frame sequencer with registered strobes; every output follows the state it enters.
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_q      <= StIdle;
      load_q       <= 1'b0;
      shift_q      <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      data_q       <= 8'h00;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      grant_q      <= 1'b0;
      shift_cnt_q  <= 4'd0;
      gap_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q   <= StLoad;
            load_q    <= 1'b1;
            busy_q    <= 1'b1;
            data_q    <= gnt_id ? req1_data : req0_data;
            par_en_q  <= cfg_parity_en;
            par_odd_q <= cfg_parity_odd;
            grant_q   <= gnt_id;
          end
        end
        StLoad: begin
          state_q      <= StShift;
          load_q       <= 1'b0;
          shift_q      <= 1'b1;
          shift_cnt_q  <= 4'd0;
          frame_done_q <= 1'b0;
        end
        StShift: begin
          if (shift_cnt_q == last_shift) begin
            shift_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= StGap;
              gap_cnt_q <= '0;
            end
          end else begin
            shift_cnt_q  <= shift_cnt_q + 4'd1;
            // Pulse lands on the cycle whose count equals last_shift.
            frame_done_q <= (shift_cnt_q == (last_shift - 4'd1));
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign load       = load_q;
  assign shift      = shift_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign p_data_out = data_q;
  assign grant_id   = grant_q;
  assign parity_bit = parity_calc(data_q, par_en_q, par_odd_q);

endmodule

// File: tb/tb_uart_tx_arb_ctrl.sv
// Bench for uart_tx_arb_ctrl: frames are observed as whole transactions and
// compared against a frame-level model of arbitration, timing and parity.
module tb_uart_tx_arb_ctrl;

  logic       tx_clk = 1'b0;
  logic       tx_rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       cfg_parity_en = 1'b0, cfg_parity_odd = 1'b0;
  logic       load, shift, parity_bit, busy, grant_id, frame_done;
  logic [7:0] p_data_out;

  logic       g_req1_valid = 1'b0, g_cfg_en = 1'b1, g_cfg_odd = 1'b0;
  logic [7:0] g_req1_data = 8'h00;
  logic       g_req0_ready, g_req1_ready, g_load, g_shift, g_parity_bit, g_busy;
  logic       g_grant_id, g_frame_done;
  logic [7:0] g_p_data_out;

  int   checks = 0;
  int   failures = 0;
  logic last_gnt = 1'b1;

  always #5 tx_clk = ~tx_clk;

  uart_tx_arb_ctrl #(.GAP_CYCLES(1)) u_dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .load(load), .shift(shift), .p_data_out(p_data_out), .parity_bit(parity_bit),
    .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
  );

  uart_tx_arb_ctrl #(.GAP_CYCLES(0)) u_dut_g0 (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .req0_valid(1'b0), .req0_data(8'h00), .req0_ready(g_req0_ready),
    .req1_valid(g_req1_valid), .req1_data(g_req1_data), .req1_ready(g_req1_ready),
    .cfg_parity_en(g_cfg_en), .cfg_parity_odd(g_cfg_odd),
    .load(g_load), .shift(g_shift), .p_data_out(g_p_data_out), .parity_bit(g_parity_bit),
    .busy(g_busy), .grant_id(g_grant_id), .frame_done(g_frame_done)
  );

  typedef struct {
    logic timeout, both_ready, overlap, ready_busy, acc_id, v0, v1, en, odd, par, gid;
    logic [7:0] d0, d1, data, loads, shifts, dones, gaps, load_idx, done_idx, idle_idx;
  } frame_t;

  // ---------------- reference model ----------------
  function automatic logic exp_winner(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  function automatic logic [7:0] exp_shifts(input logic en);
    return en ? 8'd10 : 8'd9;
  endfunction

  function automatic logic exp_parity(input logic [7:0] d, input logic en, input logic odd);
    int ones;
    if (!en) return 1'b1;
    ones = $countones(d);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // Watches one frame from acceptance back to IDLE; indices count cycles after acceptance.
  task automatic observe(input bit hold, input int flip_at, input logic [1:0] flip_mask,
                         output frame_t f);
    f = '{default: 0};
    f.timeout = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 0) #1; else @(negedge tx_clk);
      if (req0_ready || req1_ready) begin
        f.timeout = 1'b0;
        f.both_ready = req0_ready && req1_ready;
        f.acc_id = req1_ready;
        f.v0 = req0_valid; f.v1 = req1_valid;
        f.d0 = req0_data;  f.d1 = req1_data;
        f.en = cfg_parity_en; f.odd = cfg_parity_odd;
        break;
      end
    end
    if (f.timeout) return;
    @(posedge tx_clk); #1;
    if (!hold) begin
      if (f.acc_id) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
    f.timeout = 1'b1;
    for (int k = 1; k < 40; k++) begin
      @(negedge tx_clk);
      if (load && shift) f.overlap = 1'b1;
      if (busy && (req0_ready || req1_ready)) f.ready_busy = 1'b1;
      if (load) begin
        f.loads++; f.load_idx = 8'(k);
        f.data = p_data_out; f.par = parity_bit; f.gid = grant_id;
      end
      if (shift) begin
        f.shifts++;
        if (int'(f.shifts) == flip_at)
          {cfg_parity_en, cfg_parity_odd} = {cfg_parity_en, cfg_parity_odd} ^ flip_mask;
      end
      if (frame_done) begin f.dones++; f.done_idx = 8'(k); end
      if (busy && !load && !shift) f.gaps++;
      if (!busy) begin f.timeout = 1'b0; f.idle_idx = 8'(k); break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    tx_rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h77; req1_data = 8'h88; cfg_parity_en = 1'b1;
    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    checks++;
    if ({load, shift, frame_done, busy, req0_ready, req1_ready, p_data_out, parity_bit, grant_id}
        !== {6'b0, 8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b",
               {load, shift, frame_done, busy, req0_ready, req1_ready, p_data_out, parity_bit,
                grant_id}, {6'b0, 8'h00, 1'b1, 1'b0});
    end
    checks++;
    if ({g_load, g_busy, g_req1_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_gap0 got=%b want=000", {g_load, g_busy, g_req1_ready});
    end
    @(posedge tx_clk); #1;
    tx_rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    last_gnt = 1'b1;
    @(negedge tx_clk);
  endtask

  task automatic test_single;
    frame_t f;
    logic id; logic [7:0] s;
    req0_data = 8'hA5; req0_valid = 1'b1; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
    observe(1'b0, 0, 2'b00, f);
    id = exp_winner(f.v0, f.v1, last_gnt); s = exp_shifts(f.en);
    checks++;
    if ({f.timeout, f.both_ready, f.overlap, f.ready_busy, f.loads, f.dones, f.load_idx}
        !== {4'b0, 8'd1, 8'd1, 8'd1}) begin
      failures++;
      $display("FAIL single_proto got=%h want=%h",
               {f.timeout, f.both_ready, f.overlap, f.ready_busy, f.loads, f.dones, f.load_idx},
               {4'b0, 8'd1, 8'd1, 8'd1});
    end
    checks++;
    if ({f.shifts, f.done_idx, f.gaps, f.idle_idx} !== {s, s + 8'd1, 8'd1, s + 8'd3}) begin
      failures++;
      $display("FAIL single_timing got=%h want=%h", {f.shifts, f.done_idx, f.gaps, f.idle_idx},
               {s, s + 8'd1, 8'd1, s + 8'd3});
    end
    checks++;
    if ({f.acc_id, f.gid, f.data, f.par} !== {1'b0, 1'b0, 8'hA5, 1'b0}) begin
      failures++;
      $display("FAIL single_payload got=%h want=%h", {f.acc_id, f.gid, f.data, f.par},
               {1'b0, 1'b0, 8'hA5, 1'b0});
    end
    last_gnt = id;
  endtask

  task automatic test_parity;
    frame_t f;
    logic [1:0] cfg [2];
    cfg[0] = 2'b00; cfg[1] = 2'b11;
    for (int i = 0; i < 2; i++) begin
      logic id, p; logic [7:0] s;
      req0_data = 8'hFF; req0_valid = 1'b1;
      {cfg_parity_en, cfg_parity_odd} = cfg[i];
      observe(1'b0, 0, 2'b00, f);
      id = exp_winner(f.v0, f.v1, last_gnt); s = exp_shifts(f.en);
      p = exp_parity(8'hFF, f.en, f.odd);
      checks++;
      if ({f.shifts, f.done_idx, f.dones, f.overlap} !== {s, s + 8'd1, 8'd1, 1'b0}) begin
        failures++;
        $display("FAIL parity_timing[%0d] got=%h want=%h", i,
                 {f.shifts, f.done_idx, f.dones, f.overlap}, {s, s + 8'd1, 8'd1, 1'b0});
      end
      checks++;
      if ({f.acc_id, f.data, f.par} !== {id, 8'hFF, p}) begin
        failures++;
        $display("FAIL parity_payload[%0d] got=%h want=%h", i, {f.acc_id, f.data, f.par},
                 {id, 8'hFF, p});
      end
      last_gnt = id;
    end
  endtask

  task automatic test_round_robin;
    frame_t f;
    logic prev_id = 1'bx;
    req0_data = 8'h01; req1_data = 8'h02; req0_valid = 1'b1; req1_valid = 1'b1;
    cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic id; logic [7:0] s;
      observe(1'b1, 0, 2'b00, f);
      id = exp_winner(f.v0, f.v1, last_gnt); s = exp_shifts(f.en);
      checks++;
      if ({f.timeout, f.both_ready, f.acc_id, f.gid, f.data, f.par}
          !== {2'b00, id, id, id ? 8'h02 : 8'h01, exp_parity(id ? 8'h02 : 8'h01, 1'b1, 1'b0)})
      begin
        failures++;
        $display("FAIL rr_grant[%0d] got=%h want=%h", i,
                 {f.timeout, f.both_ready, f.acc_id, f.gid, f.data, f.par},
                 {2'b00, id, id, id ? 8'h02 : 8'h01,
                  exp_parity(id ? 8'h02 : 8'h01, 1'b1, 1'b0)});
      end
      checks++;
      if (f.idle_idx !== s + 8'd3 || f.acc_id === prev_id) begin
        failures++;
        $display("FAIL rr_spacing[%0d] got idle=%0d id=%b want idle=%0d prev=%b", i,
                 f.idle_idx, f.acc_id, s + 8'd3, prev_id);
      end
      prev_id = f.acc_id;
      last_gnt = id;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_cfg_change;
    frame_t f1, f2;
    req0_data = 8'h3C; req0_valid = 1'b1; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
    observe(1'b1, 3, 2'b10, f1);
    last_gnt = exp_winner(f1.v0, f1.v1, last_gnt);
    observe(1'b0, 0, 2'b00, f2);
    last_gnt = exp_winner(f2.v0, f2.v1, last_gnt);
    checks++;
    if ({f1.shifts, f1.done_idx, f1.par} !== {8'd10, 8'd11, exp_parity(8'h3C, 1'b1, 1'b0)}) begin
      failures++;
      $display("FAIL cfg_current got=%h want=%h", {f1.shifts, f1.done_idx, f1.par},
               {8'd10, 8'd11, exp_parity(8'h3C, 1'b1, 1'b0)});
    end
    checks++;
    if ({f2.shifts, f2.done_idx, f2.par} !== {8'd9, 8'd10, 1'b1}) begin
      failures++;
      $display("FAIL cfg_next got=%h want=%h", {f2.shifts, f2.done_idx, f2.par},
               {8'd9, 8'd10, 1'b1});
    end
  endtask

  task automatic test_drop;
    frame_t f;
    logic id;
    int bad = 0;
    req0_data = 8'h5A; req0_valid = 1'b1; cfg_parity_en = 1'b0;
    fork
      observe(1'b0, 0, 2'b00, f);
      begin
        repeat (4) @(negedge tx_clk);
        req1_data = 8'hEE; req1_valid = 1'b1;
        repeat (3) @(negedge tx_clk);
        req1_valid = 1'b0;
      end
    join
    last_gnt = exp_winner(f.v0, f.v1, last_gnt);
    for (int i = 0; i < 3; i++) begin
      @(negedge tx_clk);
      if (busy || req0_ready || req1_ready || load) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL drop_idle got=%0d active cycles want=0", bad);
    end
    req0_data = 8'h11; req1_data = 8'h22; req0_valid = 1'b1; req1_valid = 1'b1;
    observe(1'b0, 0, 2'b00, f);
    id = exp_winner(f.v0, f.v1, last_gnt);
    checks++;
    if ({f.timeout, f.acc_id, f.data} !== {1'b0, id, id ? 8'h22 : 8'h11}) begin
      failures++;
      $display("FAIL drop_next got=%h want=%h", {f.timeout, f.acc_id, f.data},
               {1'b0, id, id ? 8'h22 : 8'h11});
    end
    last_gnt = id;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_midframe;
    frame_t f;
    int nshift = 0, ndone = 0;
    bit got = 0;
    logic id;
    req0_data = 8'hC3; req0_valid = 1'b1; cfg_parity_en = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i == 0) #1; else @(negedge tx_clk);
      got = req0_ready;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rstmid_accept got=no ready want=ready");
    end
    @(posedge tx_clk); #1;
    req0_valid = 1'b0;
    for (int k = 0; k < 20 && nshift < 5; k++) begin
      @(negedge tx_clk);
      if (shift) nshift++;
      if (frame_done) ndone++;
    end
    tx_rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h4B; req1_data = 8'hB4;
    @(negedge tx_clk);
    if (frame_done) ndone++;
    checks++;
    if ({load, shift, frame_done, busy, req0_ready, req1_ready, p_data_out, parity_bit, grant_id}
        !== {6'b0, 8'h00, 1'b1, 1'b0} || ndone != 0 || nshift != 5) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b done=%0d shifts=%0d want=%b done=0 shifts=5",
               {load, shift, frame_done, busy, req0_ready, req1_ready, p_data_out, parity_bit,
                grant_id}, ndone, nshift, {6'b0, 8'h00, 1'b1, 1'b0});
    end
    @(posedge tx_clk); #1;
    tx_rst = 1'b0;
    last_gnt = 1'b1;
    observe(1'b0, 0, 2'b00, f);
    id = exp_winner(f.v0, f.v1, last_gnt);
    checks++;
    if ({f.timeout, f.acc_id, f.data, f.loads, f.shifts, f.dones, f.idle_idx}
        !== {1'b0, id, id ? 8'hB4 : 8'h4B, 8'd1, 8'd10, 8'd1, 8'd13}) begin
      failures++;
      $display("FAIL rstmid_restart got=%h want=%h",
               {f.timeout, f.acc_id, f.data, f.loads, f.shifts, f.dones, f.idle_idx},
               {1'b0, id, id ? 8'hB4 : 8'h4B, 8'd1, 8'd10, 8'd1, 8'd13});
    end
    last_gnt = id;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_gap0;
    int r_idx[$], l_idx[$], d_idx[$];
    g_req1_data = 8'h3C; g_cfg_en = 1'b1; g_cfg_odd = 1'b0; g_req1_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 0) #1; else @(negedge tx_clk);
      if (g_req1_ready) r_idx.push_back(c);
      if (g_load) l_idx.push_back(c);
      if (g_frame_done) d_idx.push_back(c);
    end
    g_req1_valid = 1'b0;
    checks++;
    if (r_idx.size() < 2 || l_idx.size() < 2 || d_idx.size() < 1) begin
      failures++;
      $display("FAIL gap0_events got ready=%0d load=%0d done=%0d want >=2 >=2 >=1",
               r_idx.size(), l_idx.size(), d_idx.size());
    end else begin
      checks++;
      if (d_idx[0] != r_idx[0] + 11 || l_idx[0] != r_idx[0] + 1) begin
        failures++;
        $display("FAIL gap0_first got done=%0d load=%0d want done=%0d load=%0d",
                 d_idx[0], l_idx[0], r_idx[0] + 11, r_idx[0] + 1);
      end
      checks++;
      if (r_idx[1] != d_idx[0] + 1 || l_idx[1] != r_idx[1] + 1) begin
        failures++;
        $display("FAIL gap0_b2b got ready=%0d load=%0d want ready=%0d load=%0d",
                 r_idx[1], l_idx[1], d_idx[0] + 1, r_idx[1] + 1);
      end
    end
    repeat (14) @(negedge tx_clk);
  endtask

  task automatic test_random;
    frame_t f;
    for (int i = 0; i < 25; i++) begin
      logic id, p; logic [7:0] s, d;
      if (req0_valid && ($urandom_range(3) == 0)) req0_valid = 1'b0;
      if (req1_valid && ($urandom_range(3) == 0)) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(1) == 1) begin
        req0_valid = 1'b1; req0_data = 8'($urandom);
      end
      if (!req1_valid && $urandom_range(1) == 1) begin
        req1_valid = 1'b1; req1_data = 8'($urandom);
      end
      if (!req0_valid && !req1_valid) begin
        req0_valid = 1'b1; req0_data = 8'($urandom);
      end
      {cfg_parity_en, cfg_parity_odd} = 2'($urandom);
      observe(1'b0, $urandom_range(9), 2'($urandom), f);
      id = exp_winner(f.v0, f.v1, last_gnt);
      d = id ? f.d1 : f.d0;
      s = exp_shifts(f.en);
      p = exp_parity(d, f.en, f.odd);
      checks++;
      if ({f.timeout, f.both_ready, f.overlap, f.ready_busy, f.loads, f.dones, f.load_idx}
          !== {4'b0, 8'd1, 8'd1, 8'd1}) begin
        failures++;
        $display("FAIL rand_proto[%0d] got=%h want=%h", i,
                 {f.timeout, f.both_ready, f.overlap, f.ready_busy, f.loads, f.dones, f.load_idx},
                 {4'b0, 8'd1, 8'd1, 8'd1});
      end
      checks++;
      if ({f.shifts, f.done_idx, f.gaps, f.idle_idx} !== {s, s + 8'd1, 8'd1, s + 8'd3}) begin
        failures++;
        $display("FAIL rand_timing[%0d] got=%h want=%h", i,
                 {f.shifts, f.done_idx, f.gaps, f.idle_idx}, {s, s + 8'd1, 8'd1, s + 8'd3});
      end
      checks++;
      if ({f.acc_id, f.gid, f.data, f.par} !== {id, id, d, p}) begin
        failures++;
        $display("FAIL rand_payload[%0d] got=%h want=%h", i, {f.acc_id, f.gid, f.data, f.par},
                 {id, id, d, p});
      end
      last_gnt = id;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_round_robin();
    test_cfg_change();
    test_drop();
    test_reset_midframe();
    test_gap0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
